// File: rtl/sync_w2r_gray.sv
// Write-pointer synchroniser for the read side of an async FIFO.
// Brings the Gray-coded write pointer into rclk through STAGES flops, decodes it
// to binary and derives fill level, empty/almost-empty, an advance pulse and
// sticky integrity errors against the local read pointer.
module sync_w2r_gray #(
  parameter int ASIZE         = 4,
  parameter int STAGES        = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [ASIZE:0]   wptr_gray,
  input  logic [ASIZE:0]   rptr_bin,
  input  logic             err_clr,
  output logic [ASIZE:0]   rq_wptr_gray,
  output logic [ASIZE:0]   rq_wptr_bin,
  output logic [ASIZE:0]   level,
  output logic             empty,
  output logic             almost_empty,
  output logic             wptr_adv,
  output logic             err_multibit,
  output logic             err_overrun
);

  localparam int PW = ASIZE + 1;
  localparam logic [ASIZE:0] DEPTH     = PW'(2 ** ASIZE);
  localparam logic [ASIZE:0] AE_THRESH = PW'(AEMPTY_THRESH);

  logic [ASIZE:0] sync_q [STAGES];
  logic [ASIZE:0] prev_gray;
  logic           prev_valid;
  logic [ASIZE:0] b;
  logic [ASIZE:0] level_next;
  logic           multibit_hit;
  logic           overrun_hit;

  assign rq_wptr_gray = sync_q[STAGES-1];

  // Gray-to-binary decode of the synchronised pointer, MSB down.
  always_comb begin
    logic acc;
    b   = '0;
    acc = rq_wptr_gray[ASIZE];
    b[ASIZE] = acc;
    for (int unsigned i = ASIZE; i > 0; i--) begin
      acc      = acc ^ rq_wptr_gray[i-1];
      b[i-1]   = acc;
    end
  end

  // Level and error conditions evaluated from this edge's decoded pointer.
  always_comb begin
    level_next   = b - rptr_bin;
    overrun_hit  = (level_next > DEPTH);
    multibit_hit = prev_valid && ($countones(rq_wptr_gray ^ prev_gray) > 1);
  end

  // Synchroniser chain plus registered pointer, level and status outputs.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_gray    <= '0;
      prev_valid   <= 1'b0;
      rq_wptr_bin  <= '0;
      level        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      wptr_adv     <= 1'b0;
    end else begin
      sync_q[0] <= wptr_gray;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_gray    <= rq_wptr_gray;
      prev_valid   <= 1'b1;
      rq_wptr_bin  <= b;
      level        <= level_next;
      empty        <= (b == rptr_bin);
      almost_empty <= (level_next <= AE_THRESH);
      wptr_adv     <= (b != rq_wptr_bin);
    end
  end

  // Sticky error flags: a new set condition wins over a simultaneous clear.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      err_multibit <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (multibit_hit)  err_multibit <= 1'b1;
      else if (err_clr)  err_multibit <= 1'b0;
      if (overrun_hit)   err_overrun  <= 1'b1;
      else if (err_clr)  err_overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_w2r_gray.sv
// Bench for sync_w2r_gray: STAGES=2 and STAGES=3 instances on shared stimulus,
// each compared every cycle against a queue-based reference model.
module tb_sync_w2r_gray;

  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int TH    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rrst, err_clr;
  logic [4:0] wptr_gray, rptr_bin;

  logic [4:0] rqg [2];
  logic [4:0] rqb [2];
  logic [4:0] lvl [2];
  logic       emp [2];
  logic       ae  [2];
  logic       adv [2];
  logic       emb [2];
  logic       eov [2];

  sync_w2r_gray #(.ASIZE(ASIZE), .STAGES(2), .AEMPTY_THRESH(TH)) u_s2 (
    .rclk(clk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_bin(rptr_bin),
    .err_clr(err_clr), .rq_wptr_gray(rqg[0]), .rq_wptr_bin(rqb[0]),
    .level(lvl[0]), .empty(emp[0]), .almost_empty(ae[0]), .wptr_adv(adv[0]),
    .err_multibit(emb[0]), .err_overrun(eov[0])
  );

  sync_w2r_gray #(.ASIZE(ASIZE), .STAGES(3), .AEMPTY_THRESH(TH)) u_s3 (
    .rclk(clk), .rrst(rrst), .wptr_gray(wptr_gray), .rptr_bin(rptr_bin),
    .err_clr(err_clr), .rq_wptr_gray(rqg[1]), .rq_wptr_bin(rqb[1]),
    .level(lvl[1]), .empty(emp[1]), .almost_empty(ae[1]), .wptr_adv(adv[1]),
    .err_multibit(emb[1]), .err_overrun(eov[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         stg [2] = '{2, 3};
  logic [4:0] hist [$];
  int         cnt;
  logic [4:0] m_rqg [2];
  logic [4:0] m_prev [2];
  logic [4:0] m_bin [2];
  logic [4:0] m_lvl [2];
  logic       m_emp [2];
  logic       m_ae  [2];
  logic       m_adv [2];
  logic       m_mb  [2];
  logic       m_ov  [2];

  function automatic logic [4:0] gray(input logic [4:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] r;
    r = g;
    for (int i = 1; i < 5; i++) r = r ^ (g >> i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] w, input logic [4:0] r, input logic clr, input logic rst);
    logic [4:0] b, lv;
    wptr_gray = w;
    rptr_bin  = r;
    err_clr   = clr;
    rrst      = rst;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      cnt = 0;
      for (int d = 0; d < 2; d++) begin
        m_rqg[d] = '0; m_prev[d] = '0; m_bin[d] = '0; m_lvl[d] = '0;
        m_emp[d] = 1'b1; m_ae[d] = 1'b1; m_adv[d] = 1'b0;
        m_mb[d] = 1'b0; m_ov[d] = 1'b0;
      end
    end else begin
      hist.push_back(w);
      for (int d = 0; d < 2; d++) begin
        b  = g2b(m_rqg[d]);
        lv = b - r;
        m_adv[d] = (b != m_bin[d]);
        m_bin[d] = b;
        m_lvl[d] = lv;
        m_emp[d] = (lv == 0);
        m_ae[d]  = (lv <= TH);
        m_ov[d]  = (lv > DEPTH) || (m_ov[d] && !clr);
        m_mb[d]  = (cnt >= 1 && $countones(m_rqg[d] ^ m_prev[d]) > 1) || (m_mb[d] && !clr);
        m_prev[d] = m_rqg[d];
        m_rqg[d] = (hist.size() >= stg[d]) ? hist[hist.size() - stg[d]] : 5'd0;
      end
      cnt++;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s%0d_rq_gray", stg[d]), rqg[d], m_rqg[d]);
      chk($sformatf("s%0d_rq_bin",  stg[d]), rqb[d], m_bin[d]);
      chk($sformatf("s%0d_level",   stg[d]), lvl[d], m_lvl[d]);
      chk($sformatf("s%0d_empty",   stg[d]), emp[d], m_emp[d]);
      chk($sformatf("s%0d_aempty",  stg[d]), ae[d],  m_ae[d]);
      chk($sformatf("s%0d_adv",     stg[d]), adv[d], m_adv[d]);
      chk($sformatf("s%0d_err_mb",  stg[d]), emb[d], m_mb[d]);
      chk($sformatf("s%0d_err_ov",  stg[d]), eov[d], m_ov[d]);
    end
  endtask

  logic [4:0] wb, rb, wg, diff;

  initial begin
    // Reset with all-ones pointer on the input
    step(5'h1f, 5'd0, 1'b0, 1'b1);
    step(5'h1f, 5'd0, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      chk("rst_empty",  emp[d], 1'b1);
      chk("rst_aempty", ae[d],  1'b1);
      chk("rst_level",  lvl[d], 5'd0);
      chk("rst_err_mb", emb[d], 1'b0);
      chk("rst_err_ov", eov[d], 1'b0);
    end
    wb = 5'd0; rb = 5'd0;
    repeat (5) step(gray(wb), rb, 1'b0, 1'b0);

    // Latency 0 -> 1
    wb = 5'd1;
    step(gray(wb), rb, 1'b0, 1'b0);
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("lat_s2_rq_gray", rqg[0], 5'd1);
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("lat_s2_rq_bin", rqb[0], 5'd1);
    chk("lat_s2_level",  lvl[0], 5'd1);
    chk("lat_s2_empty",  emp[0], 1'b0);
    chk("lat_s2_adv",    adv[0], 1'b1);
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("lat_s2_adv_end", adv[0], 1'b0);
    chk("lat_s3_adv",     adv[1], 1'b1);

    // Fill to DEPTH, then drain to one entry
    repeat (15) begin wb++; step(gray(wb), rb, 1'b0, 1'b0); end
    repeat (4) step(gray(wb), rb, 1'b0, 1'b0);
    chk("full_level", lvl[0], 5'd16);
    chk("full_err_ov", eov[0], 1'b0);
    rb = 5'd15;
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("drain_level",  lvl[0], 5'd1);
    chk("drain_aempty", ae[0],  1'b1);

    // Wrap through 31 -> 0 -> 2
    repeat (15) begin wb++; step(gray(wb), rb, 1'b0, 1'b0); end
    repeat (4) step(gray(wb), rb, 1'b0, 1'b0);
    rb = 5'd30;
    repeat (2) step(gray(wb), rb, 1'b0, 1'b0);
    chk("wrap_lvl_31", lvl[0], 5'd1);
    wb = 5'd0; rb = 5'd31;
    repeat (4) step(gray(wb), rb, 1'b0, 1'b0);
    chk("wrap_lvl_0", lvl[0], 5'd1);
    wb = 5'd1; step(gray(wb), rb, 1'b0, 1'b0);
    wb = 5'd2; repeat (4) step(gray(wb), rb, 1'b0, 1'b0);
    rb = 5'd0; repeat (2) step(gray(wb), rb, 1'b0, 1'b0);
    chk("wrap_lvl_2", lvl[0], 5'd2);
    chk("wrap_err_mb", emb[0], 1'b0);
    chk("wrap_err_ov", eov[0], 1'b0);

    // Random producer/consumer traffic with random clears
    repeat (150) begin
      diff = wb - rb;
      if ($urandom_range(0, 1) == 1 && diff < 5'd16) wb++;
      if ($urandom_range(0, 1) == 1 && rb != m_bin[1]) rb++;
      step(gray(wb), rb, ($urandom_range(0, 3) == 0), 1'b0);
    end
    repeat (6) step(gray(wb), rb, 1'b0, 1'b0);

    // Multi-bit Gray jump, sticky, set-beats-clear, then clear alone
    wg = gray(wb) ^ 5'b00011;
    repeat (5) step(wg, rb, 1'b0, 1'b0);
    chk("mb_set_s2", emb[0], 1'b1);
    chk("mb_set_s3", emb[1], 1'b1);
    wg = wg ^ 5'b00011;
    step(wg, rb, 1'b0, 1'b0);
    step(wg, rb, 1'b0, 1'b0);
    step(wg, rb, 1'b1, 1'b0);
    chk("mb_set_beats_clr", emb[0], 1'b1);
    repeat (3) step(wg, rb, 1'b0, 1'b0);
    step(wg, rb, 1'b1, 1'b0);
    chk("mb_clr_s2", emb[0], 1'b0);
    chk("mb_clr_s3", emb[1], 1'b0);
    wb = g2b(wg); rb = wb;
    repeat (4) step(gray(wb), rb, 1'b1, 1'b0);
    chk("post_mb_ov_clr", eov[0], 1'b0);

    // Overrun via read pointer (1-edge latency)
    rb = wb - 5'd20;
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("ov_rptr_s2", eov[0], 1'b1);
    chk("ov_rptr_s3", eov[1], 1'b1);
    repeat (3) step(gray(wb), rb, 1'b0, 1'b0);
    chk("ov_sticky", eov[0], 1'b1);
    rb = wb;
    step(gray(wb), rb, 1'b1, 1'b0);
    chk("ov_clr", eov[0], 1'b0);

    // Overrun via write pointer: STAGES=3 lags by one edge
    repeat (3) step(gray(wb), rb, 1'b0, 1'b0);
    repeat (17) begin wb++; step(gray(wb), rb, 1'b0, 1'b0); end
    step(gray(wb), rb, 1'b0, 1'b0);
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("ov_wptr_s2", eov[0], 1'b1);
    chk("ov_wptr_s3_early", eov[1], 1'b0);
    step(gray(wb), rb, 1'b0, 1'b0);
    chk("ov_wptr_s3", eov[1], 1'b1);
    rb = wb;
    repeat (4) step(gray(wb), rb, 1'b1, 1'b0);

    // Reset mid-operation, then re-propagation and more traffic
    repeat (3) begin wb++; step(gray(wb), rb, 1'b0, 1'b0); end
    step(gray(wb), rb, 1'b0, 1'b1);
    chk("mid_rst_rq_gray", rqg[0], 5'd0);
    chk("mid_rst_level",   lvl[0], 5'd0);
    chk("mid_rst_empty",   emp[0], 1'b1);
    chk("mid_rst_err_ov",  eov[0], 1'b0);
    repeat (6) step(gray(wb), rb, 1'b0, 1'b0);
    repeat (60) begin
      diff = wb - rb;
      if ($urandom_range(0, 1) == 1 && diff < 5'd16) wb++;
      if ($urandom_range(0, 1) == 1 && rb != m_bin[1]) rb++;
      step(gray(wb), rb, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
